key_scan: RTL and testbench



---
 rtl/keypad_pkg.sv | 14 +
 rtl/col_sync.sv | 27 ++
 rtl/key_scan.sv | 111 +++++++++++
 tb/tb_key_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Keypad geometry and key-vector type shared by the keypad front end and core.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int KEYS = ROWS * COLS;

  typedef logic [KEYS-1:0] keyvec_t;

  function automatic int unsigned key_idx(input int unsigned r, input int unsigned c);
    return r * COLS + c;
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for asynchronous inputs; idles at all-ones so
// pulled-up active-low lines read as inactive out of reset.
module col_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// Matrix keypad scanner: strobes rows, assembles a full-frame snapshot and
// accepts it into keystroke after DB_COUNT identical consecutive frames.
module key_scan #(
  parameter int ROWS     = keypad_pkg::ROWS,
  parameter int COLS     = keypad_pkg::COLS,
  parameter int SCAN_DIV = 50000,
  parameter int DB_COUNT = 4
) (
  input  logic                clk_raw,
  input  logic                rst,
  output logic [ROWS-1:0]     row_n,
  input  logic [COLS-1:0]     col_n,
  output keypad_pkg::keyvec_t keystroke,
  output keypad_pkg::keyvec_t key_press,
  output logic                frame_done
);

  import keypad_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [AW-1:0] AGREE_MAX = AW'(DB_COUNT - 1);

  logic [COLS-1:0] col_s;

  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   agree_q, agree_d;
  logic [ROWS-1:0] row_n_q, row_n_d;
  keyvec_t         raw_q, raw_d;
  keyvec_t         last_q, last_d;
  keyvec_t         ks_q, ks_d;
  keyvec_t         kp_q, kp_d;
  logic            fd_q;
  logic            sample;
  logic            frame_end;

  col_sync #(
    .WIDTH(COLS)
  ) u_col_sync (
    .clk_i  (clk_raw),
    .rst_i  (rst),
    .async_i(col_n),
    .sync_o (col_s)
  );

  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (row_q == ROW_LAST);

    div_d = sample ? '0 : div_q + 1'b1;
    row_d = row_q;
    if (sample) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    row_n_d        = '1;
    row_n_d[row_d] = 1'b0;

    // raw_d already holds the last row at frame end, so the frame is judged
    // on the same edge that captures it and outputs move with frame_done.
    raw_d = raw_q;
    if (sample) raw_d[row_q*COLS +: COLS] = ~col_s;

    agree_d = agree_q;
    last_d  = last_q;
    ks_d    = ks_q;
    kp_d    = '0;
    if (frame_end) begin
      if (raw_d == last_q) agree_d = (agree_q == AGREE_MAX) ? agree_q : agree_q + 1'b1;
      else                 agree_d = '0;
      last_d = raw_d;
      if ((agree_d == AGREE_MAX) && (raw_d != ks_q)) begin
        ks_d = raw_d;
        kp_d = raw_d & ~ks_q;
      end
    end
  end

  always_ff @(posedge clk_raw) begin
    if (rst) begin
      div_q   <= '0;
      row_q   <= '0;
      agree_q <= '0;
      row_n_q <= {{(ROWS-1){1'b1}}, 1'b0};
      raw_q   <= '0;
      last_q  <= '0;
      ks_q    <= '0;
      kp_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      row_q   <= row_d;
      agree_q <= agree_d;
      row_n_q <= row_n_d;
      raw_q   <= raw_d;
      last_q  <= last_d;
      ks_q    <= ks_d;
      kp_q    <= kp_d;
      fd_q    <= frame_end;
    end
  end

  assign row_n      = row_n_q;
  assign keystroke  = ks_q;
  assign key_press  = kp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad contact model, frame-level debounce model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_key_scan;

  import keypad_pkg::*;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = ROWS * SD;
  localparam int HLEN  = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  keyvec_t         keystroke;
  keyvec_t         key_press;
  logic            frame_done;
  keyvec_t         keys = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_scan #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .SCAN_DIV(SD),
    .DB_COUNT(DB)
  ) dut (
    .clk_raw   (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .keystroke (keystroke),
    .key_press (key_press),
    .frame_done(frame_done)
  );

  // closed contact pulls its column low while its row is driven
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_n[r] && keys[key_idx(r, c)]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // cycle index since the last reset edge (cycle 0 = first cycle out of reset)
  int      cur_t   = 0;
  bit      started = 1'b0;
  int      pulses  = 0;
  logic [COLS-1:0] hist [HLEN];
  keyvec_t fq[$];
  keyvec_t m_ks = '0;
  keyvec_t m_kp = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      cur_t   = 0;
      started = 1'b1;
      fq.delete();
      fq.push_back('0);
      m_ks = '0;
    end else begin
      cur_t++;
    end
  end

  initial forever begin
    keyvec_t         nf;
    logic [ROWS-1:0] er;
    bit              exp_fd;
    bit              same;
    int              f0;
    @(negedge clk);
    if (started) begin
      if (cur_t < HLEN) hist[cur_t] = col_n;
      else check("hist_range", 32'(cur_t), 32'(HLEN - 1));
      exp_fd = (cur_t >= FRAME) && (cur_t % FRAME == 0);
      m_kp = '0;
      if (exp_fd && cur_t < HLEN) begin
        // row r is read at the end of its dwell, seeing col_n from two cycles earlier
        f0 = cur_t - FRAME;
        nf = '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            nf[key_idx(r, c)] = ~hist[f0 + r*SD + SD - 3][c];
        fq.push_back(nf);
        if (fq.size() > DB) void'(fq.pop_front());
        same = 1'b1;
        for (int i = 1; i < fq.size(); i++)
          if (fq[i] != fq[0]) same = 1'b0;
        if (fq.size() == DB && same && nf != m_ks) begin
          m_kp = nf & ~m_ks;
          m_ks = nf;
        end
      end
      er = '1;
      er[(cur_t / SD) % ROWS] = 1'b0;
      check("m_row_n", 32'(row_n), 32'(er));
      check("m_frame_done", 32'(frame_done), 32'(exp_fd));
      check("m_keystroke", 32'(keystroke), 32'(m_ks));
      check("m_key_press", 32'(key_press), 32'(m_kp));
      if (key_press != '0) pulses++;
    end
  end

  task automatic goto(input int n);
    int g = 0;
    while (cur_t != n && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cur_t != n) check("goto_timeout", 32'(cur_t), 32'(n));
  endtask

  initial begin
    int p0;
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'hE);
    check("rst_keystroke", 32'(keystroke), 32'h000);
    check("rst_key_press", 32'(key_press), 32'h000);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    goto(4);  @(negedge clk); check("step_row1", 32'(row_n), 32'hD);
    goto(8);  @(negedge clk); check("step_row2", 32'(row_n), 32'hB);
    goto(12); @(negedge clk); check("step_row3", 32'(row_n), 32'h7);

    // single key (2,0) held from frame 1
    goto(16);
    keys[key_idx(2, 0)] = 1'b1;
    @(negedge clk); check("first_frame_done", 32'(frame_done), 32'h1);
    goto(17); @(negedge clk); check("frame_done_pulse", 32'(frame_done), 32'h0);
    goto(63); @(negedge clk); check("press_early", 32'(keystroke), 32'h000);
    goto(64); @(negedge clk);
    check("press_ks", 32'(keystroke), 32'h040);
    check("press_kp", 32'(key_press), 32'h040);
    goto(65); @(negedge clk); check("press_kp_end", 32'(key_press), 32'h000);

    // release (2,0): debounced with no pulse
    goto(80);
    keys[key_idx(2, 0)] = 1'b0;
    goto(127); @(negedge clk); check("release_early", 32'(keystroke), 32'h040);
    goto(128); @(negedge clk);
    check("release_ks", 32'(keystroke), 32'h000);
    check("release_kp", 32'(key_press), 32'h000);

    // bounce (1,1) every 5 cycles for two frames, then hold
    goto(144);
    p0 = pulses;
    keys[key_idx(1, 1)] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      goto(144 + 5*i);
      keys[key_idx(1, 1)] = ~keys[key_idx(1, 1)];
    end
    @(negedge clk); check("bounce_hold", 32'(keystroke), 32'h000);
    goto(207); @(negedge clk); check("bounce_early", 32'(keystroke), 32'h000);
    goto(208); @(negedge clk);
    check("bounce_ks", 32'(keystroke), 32'h010);
    check("bounce_kp", 32'(key_press), 32'h010);
    goto(224);
    keys[key_idx(1, 1)] = 1'b0;
    goto(240); @(negedge clk); check("bounce_pulses", 32'(pulses - p0), 32'd1);

    // two keys together
    goto(288);
    keys[key_idx(2, 2)] = 1'b1;
    keys[key_idx(3, 0)] = 1'b1;
    goto(336); @(negedge clk);
    check("multi_ks", 32'(keystroke), 32'h300);
    check("multi_kp", 32'(key_press), 32'h300);
    goto(352);
    keys = '0;
    goto(400); @(negedge clk); check("multi_release", 32'(keystroke), 32'h000);

    // reset mid-frame with a key accepted and still held
    goto(416);
    keys[key_idx(2, 0)] = 1'b1;
    goto(464); @(negedge clk); check("pre_rst_ks", 32'(keystroke), 32'h040);
    goto(471);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ks", 32'(keystroke), 32'h000);
    check("midrst_row_n", 32'(row_n), 32'hE);
    check("midrst_frame_done", 32'(frame_done), 32'h0);
    goto(47); @(negedge clk); check("rearm_early", 32'(keystroke), 32'h000);
    goto(48); @(negedge clk);
    check("rearm_ks", 32'(keystroke), 32'h040);
    check("rearm_kp", 32'(key_press), 32'h040);
    goto(60); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
